// File: rtl/param_fetch_pipe.sv
// Parameter-fetch stage: streams (weight, index) pairs from base_addr, fetches input[index+offset]
// and emits (value, weight) beats to the MAC with a fixed 4-cycle latency from address issue.
module param_fetch_pipe #(
    parameter int          DATA_W      = 16,
    parameter int          ADDR_W      = 16,
    parameter int          CNT_W       = 16,
    parameter int unsigned INPUT_LIMIT = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_adds,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] weight_addr,
    input  logic [DATA_W-1:0] weight_val,
    output logic [ADDR_W-1:0] index_addr,
    input  logic [DATA_W-1:0] index_val,
    output logic [ADDR_W-1:0] input_addr,
    input  logic [DATA_W-1:0] input_val,
    output logic [DATA_W-1:0] out_val,
    output logic [DATA_W-1:0] out_weight,
    output logic              out_valid,
    output logic              out_last,
    output logic              out_oob,
    output logic              busy,
    output logic              done,
    output logic [1:0]        o_dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(INPUT_LIMIT);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_offset;
    logic [ADDR_W-1:0] r_addr;
    logic              r_v1, r_l1;
    logic              r_v2, r_l2;
    logic              r_v3, r_l3, r_oob3;
    logic [DATA_W-1:0] r_w3;
    logic [ADDR_W-1:0] r_in_addr;
    logic              r_v4, r_l4, r_oob4;
    logic [DATA_W-1:0] r_w4;
    logic              r_out_valid, r_out_last, r_out_oob;
    logic [DATA_W-1:0] r_out_val, r_out_weight;

    logic [ADDR_W:0]   w_sum;
    logic              w_oob;
    logic              w_kill;

    // Index + offset carried one bit wide so a wrap past the top of memory is flagged, not aliased.
    assign w_sum  = (ADDR_W+1)'(index_val) + (ADDR_W+1)'(r_offset);
    assign w_oob  = w_sum[ADDR_W] | (w_sum >= LIMIT);
    assign w_kill = abort && (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_num    <= '0;
            r_cnt    <= '0;
            r_offset <= '0;
            r_addr   <= '0;
            r_v1     <= 1'b0;
            r_l1     <= 1'b0;
        end else if (w_kill) begin
            r_state <= S_IDLE;
            r_v1    <= 1'b0;
            r_l1    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_num    <= num_adds;
                        r_offset <= offset;
                        if (num_adds == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ISSUE;
                            r_addr  <= base_addr;
                            r_cnt   <= CNT_W'(1);
                            r_v1    <= 1'b1;
                            r_l1    <= (num_adds == CNT_W'(1));
                        end
                    end
                end
                // r_cnt counts addresses issued including the one on the bus now.
                S_ISSUE: begin
                    if (r_cnt == r_num) begin
                        r_state <= S_DRAIN;
                        r_v1    <= 1'b0;
                        r_l1    <= 1'b0;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_l1   <= ((r_cnt + CNT_W'(1)) == r_num);
                    end
                end
                S_DRAIN: begin
                    if (r_out_valid && r_out_last) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2         <= 1'b0;
            r_l2         <= 1'b0;
            r_v3         <= 1'b0;
            r_l3         <= 1'b0;
            r_oob3       <= 1'b0;
            r_w3         <= '0;
            r_in_addr    <= '0;
            r_v4         <= 1'b0;
            r_l4         <= 1'b0;
            r_oob4       <= 1'b0;
            r_w4         <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_oob    <= 1'b0;
            r_out_val    <= '0;
            r_out_weight <= '0;
        end else begin
            r_v2 <= r_v1 && !w_kill;
            r_l2 <= r_l1;
            r_v3 <= r_v2 && !w_kill;
            r_l3 <= r_l2;
            if (r_v2) begin
                r_w3      <= weight_val;
                r_in_addr <= w_sum[ADDR_W-1:0];
                r_oob3    <= w_oob;
            end
            r_v4 <= r_v3 && !w_kill;
            r_l4 <= r_l3;
            if (r_v3) begin
                r_w4   <= r_w3;
                r_oob4 <= r_oob3;
            end
            r_out_valid <= r_v4 && !w_kill;
            if (r_v4 && !w_kill) begin
                r_out_val    <= r_oob4 ? '0 : input_val;
                r_out_weight <= r_w4;
                r_out_last   <= r_l4;
                r_out_oob    <= r_oob4;
            end else begin
                r_out_last <= 1'b0;
                r_out_oob  <= 1'b0;
            end
        end
    end

    assign weight_addr = r_addr;
    assign index_addr  = r_addr;
    assign input_addr  = r_in_addr;
    assign out_val     = r_out_val;
    assign out_weight  = r_out_weight;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign out_oob     = r_out_oob;
    assign busy        = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_param_fetch_pipe.sv
// Bench for param_fetch_pipe: memory models, a job-level expected-beat model, and a per-cycle checker.
module tb_param_fetch_pipe;
  localparam int LIMIT = 'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  num_adds = '0;
  logic [15:0] base_addr = '0;
  logic [15:0] offset = '0;
  logic [15:0] weight_addr, index_addr, input_addr;
  logic [15:0] weight_val, index_val, input_val;
  logic [15:0] out_val, out_weight;
  logic        out_valid, out_last, out_oob, busy, done;
  logic [1:0]  o_dbg_state;

  logic [15:0] wmem  [0:65535];
  logic [15:0] imem  [0:65535];
  logic [15:0] inmem [0:65535];

  typedef struct packed {
    int          cyc;
    logic [15:0] val;
    logic [15:0] w;
    logic        last;
    logic        oob;
  } beat_t;

  beat_t exp_q[$];
  int    exp_done = -1;
  int    busy_lo  = 1;
  int    busy_hi  = 0;
  int    cyc      = 0;
  int    n_vec    = 0;
  int    n_err    = 0;

  param_fetch_pipe #(.DATA_W(16), .ADDR_W(16), .CNT_W(4), .INPUT_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_adds(num_adds),
    .base_addr(base_addr), .offset(offset), .weight_addr(weight_addr), .weight_val(weight_val),
    .index_addr(index_addr), .index_val(index_val), .input_addr(input_addr), .input_val(input_val),
    .out_val(out_val), .out_weight(out_weight), .out_valid(out_valid), .out_last(out_last),
    .out_oob(out_oob), .busy(busy), .done(done), .o_dbg_state(o_dbg_state)
  );

  // clock / memories
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    weight_val <= wmem[weight_addr];
    index_val  <= imem[index_addr];
    input_val  <= inmem[input_addr];
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // job-level model: what every beat of a job must carry and when
  task automatic model_job(input int n, input logic [15:0] b, input logic [15:0] o, input int s);
    logic [15:0] a;
    logic [16:0] sum;
    beat_t       bt;
    for (int k = 0; k < n; k++) begin
      a       = b + 16'(k);
      sum     = {1'b0, imem[a]} + {1'b0, o};
      bt.cyc  = s + 5 + k;
      bt.oob  = (sum >= 17'(LIMIT));
      bt.val  = bt.oob ? 16'h0 : inmem[sum[15:0]];
      bt.w    = wmem[a];
      bt.last = (k == n - 1);
      exp_q.push_back(bt);
    end
    busy_lo  = s + 1;
    busy_hi  = (n == 0) ? s : s + 4 + n;
    exp_done = (n == 0) ? s + 1 : s + 5 + n;
  endtask

  task automatic model_abort(input int a);
    while (exp_q.size() > 0 && exp_q[$].cyc > a) void'(exp_q.pop_back());
    if (exp_done > a) exp_done = -1;
    if (busy_hi > a) busy_hi = a;
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_done = -1;
    busy_lo  = 1;
    busy_hi  = 0;
  endtask

  // driver tasks: return at the negedge of cycle s+1
  task automatic start_job(input int n, input logic [15:0] b, input logic [15:0] o, output int s);
    @(negedge clk);
    start = 1'b1; num_adds = 4'(n); base_addr = b; offset = o;
    s = cyc;
    model_job(n, b, o, s);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge clk);
    abort = 1'b1;
    model_abort(cyc);
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard: per-cycle comparison against the model
  logic  ev;
  beat_t hb;
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs",
          128'({weight_addr, index_addr, input_addr, out_val, out_weight,
                out_valid, out_last, out_oob, busy, done}), 128'(0));
    end else begin
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("out_valid", 128'(out_valid), 128'(ev));
      chk("out_last", 128'(out_last), 128'(ev && exp_q[0].last));
      chk("busy", 128'(busy), 128'(cyc >= busy_lo && cyc <= busy_hi));
      chk("done", 128'(done), 128'(cyc == exp_done));
      chk("index_addr", 128'(index_addr), 128'(weight_addr));
      if (ev) begin
        hb = exp_q.pop_front();
        chk("out_val", 128'(out_val), 128'(hb.val));
        chk("out_weight", 128'(out_weight), 128'(hb.w));
        chk("out_oob", 128'(out_oob), 128'(hb.oob));
      end else begin
        chk("out_oob_idle", 128'(out_oob), 128'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  logic [15:0] wa_exp [4];
  initial begin
    int s;
    for (int i = 0; i < 65536; i++) begin
      wmem[i]  = 16'(i * 13 + 5);
      imem[i]  = 16'(i & 'hFF);
      inmem[i] = 16'(i ^ 'h5A5A);
    end
    wmem[16'h10] = 16'hA000; wmem[16'h11] = 16'hA001; wmem[16'h12] = 16'hA002;
    imem[16'h10] = 16'd1;    imem[16'h11] = 16'd2;    imem[16'h12] = 16'd3;
    inmem[16'h101] = 16'h1101; inmem[16'h102] = 16'h1102; inmem[16'h103] = 16'h1103;
    imem[16'h40] = 16'd2;  wmem[16'h40] = 16'hC0DE; imem[16'h41] = 16'd0;
    imem[16'h50] = 16'd1;  imem[16'h51] = 16'd2;    inmem[16'h0FFF] = 16'hBEEF;

    #1 rst = 1'b1;
    idle_cycles(3);
    #1 rst = 1'b0;
    idle_cycles(2);

    // three-element job with literal timing and data pins
    start_job(3, 16'h0010, 16'h0100, s);
    idle_cycles(2);
    chk("lit_input_addr0", 128'(input_addr), 128'(16'h0101));
    idle_cycles(2);
    chk("lit_beat0", 128'({out_valid, out_val, out_weight}), 128'({1'b1, 16'h1101, 16'hA000}));
    idle_cycles(2);
    chk("lit_beat2", 128'({out_valid, out_last, out_val}), 128'({1'b1, 1'b1, 16'h1103}));
    idle_cycles(1);
    chk("lit_done", 128'({done, busy}), 128'({1'b1, 1'b0}));
    idle_cycles(3);

    // zero-count job
    start_job(0, 16'h0020, 16'h0000, s);
    chk("lit_zero_done", 128'({done, busy, out_valid}), 128'({1'b1, 1'b0, 1'b0}));
    idle_cycles(3);

    // carry out of the adder, and a sum beyond the limit
    start_job(2, 16'h0040, 16'hFFFF, s);
    idle_cycles(4);
    chk("lit_oob_carry", 128'({out_valid, out_oob, out_val, out_weight}),
        128'({1'b1, 1'b1, 16'h0000, 16'hC0DE}));
    idle_cycles(6);

    // limit boundary: 0x0FFF in range, 0x1000 out
    start_job(2, 16'h0050, 16'h0FFE, s);
    idle_cycles(4);
    chk("lit_below_limit", 128'({out_oob, out_val}), 128'({1'b0, 16'hBEEF}));
    idle_cycles(1);
    chk("lit_at_limit", 128'({out_valid, out_oob, out_val}), 128'({1'b1, 1'b1, 16'h0000}));
    idle_cycles(4);

    // address wrap at the top of memory
    wa_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    start_job(4, 16'hFFFE, 16'h0000, s);
    for (int k = 0; k < 4; k++) begin
      chk("lit_weight_addr", 128'(weight_addr), 128'(wa_exp[k]));
      idle_cycles(1);
    end
    idle_cycles(8);

    // abort two cycles into a ten-element job, then a fresh job
    start_job(10, 16'h0200, 16'h0010, s);
    do_abort();
    idle_cycles(1);
    chk("lit_abort_idle", 128'({busy, out_valid}), 128'(0));
    idle_cycles(6);
    start_job(2, 16'h0210, 16'h0030, s);
    idle_cycles(10);

    // abort with beats already in flight
    start_job(10, 16'h0300, 16'h0000, s);
    idle_cycles(5);
    do_abort();
    idle_cycles(8);

    // start together with abort in IDLE: nothing launches
    @(negedge clk);
    start = 1'b1; abort = 1'b1; num_adds = 4'd5; base_addr = 16'h0400;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    idle_cycles(8);

    // largest count the counter can hold
    start_job(15, 16'h0500, 16'h0020, s);
    idle_cycles(25);

    // start pulsed mid-job is ignored
    start_job(6, 16'h0600, 16'h0040, s);
    @(negedge clk);
    start = 1'b1; num_adds = 4'd2; base_addr = 16'h0999; offset = 16'h0050;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(14);

    // asynchronous reset mid-job, then a fresh job
    start_job(8, 16'h0700, 16'h0000, s);
    idle_cycles(3);
    #2 rst = 1'b1;
    model_clear();
    idle_cycles(3);
    #1 rst = 1'b0;
    idle_cycles(2);
    start_job(2, 16'h0710, 16'h0008, s);
    idle_cycles(10);

    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
